key_assembler: RTL and testbench

KEY_ASSEMBLER -- requirements
Module: key_assembler

---
 rtl/skein_pkg.sv | 15 +
 rtl/key_assembler_word_bswap.sv | 17 +
 rtl/key_assembler.sv | 97 +++++++++
 tb/tb_key_assembler.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/skein_pkg.sv
// Shared types and defaults for the key assembler.
//   state_t       : assembler FSM state (LOAD accepting words, HOLD presenting key)
//   WORD_W_DEF    : default input word width in bits
//   NUM_WORDS_DEF : default number of words per key
package skein_pkg;

  localparam int WORD_W_DEF    = 64;
  localparam int NUM_WORDS_DEF = 16;

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/key_assembler_word_bswap.sv
// word_bswap: combinational byte reverser.
//   word    : input word, WORD_W bits (multiple of 8)
//   swapped : byte 0 of word lands in byte WORD_W/8-1, and so on
module word_bswap #(
  parameter int WORD_W = 64
) (
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] swapped
);

  localparam int NB = WORD_W / 8;

  for (genvar b = 0; b < NB; b++) begin : g_byte
    assign swapped[b*8 +: 8] = word[(NB-1-b)*8 +: 8];
  end

endmodule

// File: rtl/key_assembler.sv
// key_assembler: collects NUM_WORDS words of WORD_W bits into one key.
//   clk_i, rst_n_i          : clock, async active-low reset
//   word_i/_valid_i/_last_i : word input; last may end a key early
//   word_ready_o            : high in LOAD
//   abort_i                 : synchronous flush of any partial or held key
//   key_o/_valid_o/_len_o   : assembled key, held until key_ready_i
//   key_ready_i             : consumer accepts key_o
// Build option: define KEY_ASSEMBLER_BSWAP_EN to byte-reverse every word
// before it is stored.
module key_assembler
  import skein_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  localparam int KEY_W    = WORD_W * NUM_WORDS,
  localparam int CNT_W    = $clog2(NUM_WORDS + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              word_valid_i,
  input  logic              word_last_i,
  output logic              word_ready_o,
  input  logic              abort_i,
  output logic [KEY_W-1:0]  key_o,
  output logic              key_valid_o,
  input  logic              key_ready_i,
  output logic [CNT_W-1:0]  key_len_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_WORDS - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WORD_W-1:0]  word_st;
  logic [CNT_W-1:0]   cnt_nxt;

  assign cnt_nxt = cnt_q + CNT_W'(1);

`ifdef KEY_ASSEMBLER_BSWAP_EN
  word_bswap #(.WORD_W(WORD_W)) u_bswap (
    .word    (word_i),
    .swapped (word_st)
  );
`else
  assign word_st = word_i;
`endif

  // Slots past an early last are already zero: every path back into LOAD
  // (reset, abort, key transfer) clears the whole key register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= LOAD;
      cnt_q        <= '0;
      key_o        <= '0;
      key_len_o    <= '0;
      key_valid_o  <= 1'b0;
      word_ready_o <= 1'b1;
    end else if (abort_i) begin
      state_q      <= LOAD;
      cnt_q        <= '0;
      key_o        <= '0;
      key_len_o    <= '0;
      key_valid_o  <= 1'b0;
      word_ready_o <= 1'b1;
    end else begin
      case (state_q)
        LOAD: begin
          // word_ready_o is high throughout LOAD, so valid alone is a transfer
          if (word_valid_i) begin
            key_o[int'(cnt_q)*WORD_W +: WORD_W] <= word_st;
            cnt_q <= cnt_nxt;
            if (cnt_q == CNT_LAST || word_last_i) begin
              state_q      <= HOLD;
              key_len_o    <= cnt_nxt;
              key_valid_o  <= 1'b1;
              word_ready_o <= 1'b0;
            end
          end
        end
        HOLD: begin
          // ready rises only after this edge: no same-cycle hand-off
          if (key_ready_i) begin
            state_q      <= LOAD;
            cnt_q        <= '0;
            key_o        <= '0;
            key_len_o    <= '0;
            key_valid_o  <= 1'b0;
            word_ready_o <= 1'b1;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_key_assembler.sv
// Directed bench for key_assembler with default parameters (64 x 16).
module tb_key_assembler;

  localparam int WW = 64;
  localparam int NW = 16;
  localparam int KW = WW * NW;
  localparam int CW = $clog2(NW + 1);

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic [WW-1:0] word_i;
  logic          word_valid_i;
  logic          word_last_i;
  logic          word_ready_o;
  logic          abort_i;
  logic [KW-1:0] key_o;
  logic          key_valid_o;
  logic          key_ready_i;
  logic [CW-1:0] key_len_o;

  int passes = 0;
  int total  = 0;
  logic [KW-1:0] exp_key;

  key_assembler dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .word_i       (word_i),
    .word_valid_i (word_valid_i),
    .word_last_i  (word_last_i),
    .word_ready_o (word_ready_o),
    .abort_i      (abort_i),
    .key_o        (key_o),
    .key_valid_o  (key_valid_o),
    .key_ready_i  (key_ready_i),
    .key_len_o    (key_len_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected storage form of a word for the current build.
  function automatic logic [WW-1:0] st(input logic [WW-1:0] w);
`ifdef KEY_ASSEMBLER_BSWAP_EN
    logic [WW-1:0] r;
    for (int b = 0; b < WW/8; b++) r[b*8 +: 8] = w[(WW/8-1-b)*8 +: 8];
    return r;
`else
    return w;
`endif
  endfunction

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_key(input string tag, input logic [KW-1:0] exp);
    int bad;
    bad = -1;
    for (int s = NW-1; s >= 0; s--) if (key_o[s*WW +: WW] !== exp[s*WW +: WW]) bad = s;
    total++;
    assert (key_o === exp) passes++;
    else begin
      if (bad < 0) bad = 0;
      $error("FAIL %s slot=%0d observed=%h expected=%h", tag, bad,
             key_o[bad*WW +: WW], exp[bad*WW +: WW]);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_n_i = 1'b0; word_i = '0; word_valid_i = 0; word_last_i = 0;
    abort_i = 0; key_ready_i = 0;
    #12;
    chk("rst_ready", 64'(word_ready_o), 64'd1);
    chk("rst_kvalid", 64'(key_valid_o), 64'd0);
    chk("rst_len", 64'(key_len_o), 64'd0);
    chk_key("rst_key", '0);
    rst_n_i = 1'b1;
    tick();

    // Full key, words 0..F, consumer stalled.
    exp_key = '0;
    for (int i = 0; i < NW; i++) begin
      word_i = WW'(i); word_valid_i = 1;
      exp_key[i*WW +: WW] = st(WW'(i));
      tick();
      if (i == NW-2) chk("full_kvalid_early", 64'(key_valid_o), 64'd0);
    end
    chk("full_kvalid", 64'(key_valid_o), 64'd1);
    chk("full_slot0", key_o[63:0], st(64'h0));
    chk("full_slot15", key_o[1023:960], st(64'hF));
    chk("full_len", 64'(key_len_o), 64'd16);
    chk("full_ready", 64'(word_ready_o), 64'd0);
    chk_key("full_key", exp_key);

    // Back-pressure: 10 stalled cycles with a word offered.
    word_i = 64'hAA;
    for (int i = 0; i < 10; i++) tick();
    chk_key("bp_key_stable", exp_key);
    chk("bp_ready", 64'(word_ready_o), 64'd0);
    chk("bp_kvalid", 64'(key_valid_o), 64'd1);
    key_ready_i = 1;
    tick();
    key_ready_i = 0;
    chk("exit_kvalid", 64'(key_valid_o), 64'd0);
    chk("exit_ready", 64'(word_ready_o), 64'd1);
    chk_key("exit_cleared", '0);
    tick();
    chk("bp_slot0", key_o[63:0], st(64'hAA));
    chk("load_len0", 64'(key_len_o), 64'd0);

    // Early last: AA already in slot 0, then BB, CC(last).
    word_i = 64'hBB; tick();
    word_i = 64'hCC; word_last_i = 1; tick();
    word_valid_i = 0; word_last_i = 0;
    exp_key = '0;
    exp_key[191:0] = {st(64'hCC), st(64'hBB), st(64'hAA)};
    chk("early_kvalid", 64'(key_valid_o), 64'd1);
    chk("early_len", 64'(key_len_o), 64'd3);
    chk_key("early_key", exp_key);
    key_ready_i = 1; tick(); key_ready_i = 0;

    // Abort after 7 words, with a coincident word offered.
    for (int i = 0; i < 7; i++) begin
      word_i = 64'h100 + WW'(i); word_valid_i = 1; tick();
    end
    chk("pre_abort_slot6", key_o[6*WW +: WW], st(64'h106));
    word_i = 64'hDEAD; abort_i = 1; tick(); abort_i = 0;
    chk_key("abort_key", '0);
    chk("abort_ready", 64'(word_ready_o), 64'd1);
    chk("abort_len", 64'(key_len_o), 64'd0);

    // Fresh 16 words after abort; last on word 16 is redundant.
    exp_key = '0;
    for (int i = 0; i < NW; i++) begin
      word_i = 64'h200 + WW'(i); word_last_i = (i == NW-1);
      exp_key[i*WW +: WW] = st(64'h200 + WW'(i));
      tick();
    end
    word_valid_i = 0; word_last_i = 0;
    chk("post_abort_kvalid", 64'(key_valid_o), 64'd1);
    chk("post_abort_len", 64'(key_len_o), 64'd16);
    chk_key("post_abort_key", exp_key);

    // Abort in HOLD beats a coincident key transfer.
    key_ready_i = 1; abort_i = 1; tick(); key_ready_i = 0; abort_i = 0;
    chk("hold_abort_kvalid", 64'(key_valid_o), 64'd0);
    chk_key("hold_abort_key", '0);

    // Byte-order check with a single-word key, then async reset in HOLD.
    word_i = 64'h0102030405060708; word_valid_i = 1; word_last_i = 1; tick();
    word_valid_i = 0; word_last_i = 0;
`ifdef KEY_ASSEMBLER_BSWAP_EN
    chk("bswap_slot0", key_o[63:0], 64'h0807060504030201);
`else
    chk("bswap_slot0", key_o[63:0], 64'h0102030405060708);
`endif
    chk("one_len", 64'(key_len_o), 64'd1);
    #3 rst_n_i = 1'b0;
    #1;
    chk("arst_kvalid", 64'(key_valid_o), 64'd0);
    chk_key("arst_key", '0);
    chk("arst_ready", 64'(word_ready_o), 64'd1);
    chk("arst_len", 64'(key_len_o), 64'd0);
    #10 rst_n_i = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
